regbank_wr_demux8: RTL and testbench
====================================

// Module: regbank_wr_demux8
// PURPOSE
//  Write side of the 8 x 16-bit general register bank: accepts write requests
//  (addr, data) over a valid/ready handshake, buffers them in a small FIFO,
//  decodes the 3-bit address into one of 8 write enables, and commits one
//  entry per cycle when the pipeline allows. Exports all 8 registers flat for
//  the 8:1 read-select muxes.
// PARAMETERS
//  WIDTH   16  register / data width in bits
//  DEPTH   2   write-buffer entries; legal values 2 or 4 (power of two)
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         asynchronous, active-high reset
//  wr_valid   in   1         write request present
//  wr_ready   out  1         buffer can accept; a transfer occurs on valid&&ready
//  wr_addr    in   3         destination register index 0..7
//  wr_data    in   WIDTH     write data
//  commit_en  in   1         pipeline permits draining one buffered entry this cycle
//  regs_flat  out  8*WIDTH   reg i at [i*WIDTH +: WIDTH]
//  pend_cnt   out  clog2(DEPTH)+1  buffered entries not yet committed
//  wr_done    out  1         pulse: an entry was committed on this edge
// BEHAVIOUR
//  - Reset (async, immediate): all 8 regs = 0, FIFO empty, pend_cnt = 0,
//    wr_ready = 1, wr_done = 0. Buffered entries are discarded, not committed.
//  - wr_ready = (pend_cnt != DEPTH); combinational from state only, never from
//    wr_valid. When full, a pop in the same cycle does NOT raise wr_ready.
//  - Push: valid&&ready stores {addr,data} at tail; tail wraps modulo DEPTH.
//  - Commit: if commit_en && pend_cnt != 0, head entry written into
//    reg[head.addr] at the edge; head wraps modulo DEPTH; wr_done = 1 for the
//    following cycle (registered). Exactly one register write per cycle max.
//  - Latency: a request accepted at edge N with commit_en high is visible on
//    regs_flat after edge N+1 (minimum 1 cycle; no combinational path to regs).
//  - Simultaneous push and commit: both happen; pend_cnt unchanged.
//  - Empty with commit_en: no write, wr_done = 0.
//  - Order: commits strictly FIFO; two writes to the same index, last wins.
//  - Decode: one-hot enable = (1 << addr) & {8{commit}}; no register 0 special case.
//  - Unused regs hold value; no X propagation from unselected lanes.
// CONFIGURATION
//  REGBANK_WR_BYPASS_EN
//   defined  : regs_flat shows forwarded view: for each index, the youngest
//              buffered entry targeting it overrides the stored value
//              (committed state itself unchanged until commit).
//   undefined: regs_flat shows committed registers only.
// STRUCTURE
//  - Shared defs header (wisc_rf_defs.vh): NUM_REGS=8, REG_AW=3, REG_W=16,
//    write-request field layout {addr, data} and its width.
//  - One sub-module: wr_fifo (parameterised DEPTH/width, head/tail/count,
//    push/pop/full/empty). Decode, register array, bypass stay in top.
// TESTING
//  1 reset, commit_en=1, write addr=3 data=16'hBEEF -> reg3=BEEF one edge later,
//    wr_done pulse, all other regs 0, pend_cnt back to 0.
//  2 commit_en=0, push 2 writes (DEPTH=2) -> pend_cnt=2, wr_ready=0, third
//    valid held not accepted; raise commit_en -> drains in order, one per cycle.
//  3 full + push attempt + commit same cycle -> wr_ready stays 0, pend_cnt=1.
//  4 pend_cnt=1, push addr5=0x0001 while commit of addr5=0x0002 -> reg5=0002
//    then 0001; pend_cnt stays 1 then 0.
//  5 rst asserted mid-drain with 2 pending -> regs 0 immediately, pend_cnt=0,
//    nothing committed after release.
//  6 BYPASS_EN: commit_en=0, push addr7=0x1234 -> regs_flat[7] = 1234 next
//    cycle while stored reg7=0; without macro regs_flat[7]=0 until commit.

Source files
------------

// File: rtl/regbank_wr_demux8_pkg.sv
// Shared definitions for the general register bank write side: bank geometry,
// write-request layout {addr, data}, and the one-hot write-enable decode.
package regbank_wr_demux8_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;
    localparam int REG_W    = 16;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_W-1:0]  data;
    } wr_req_t;

    localparam int WR_REQ_W = $bits(wr_req_t);

    function automatic logic [NUM_REGS-1:0] dec_onehot(input logic [REG_AW-1:0] addr,
                                                       input logic              en);
        return en ? (NUM_REGS'(1) << addr) : '0;
    endfunction

endpackage

// File: rtl/regbank_wr_demux8_wr_fifo.sv
// Small circular write buffer with head/tail/count tracking.
// REGBANK_WR_BYPASS_EN additionally exposes storage and head for forwarding.
module wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
`ifdef REGBANK_WR_BYPASS_EN
    ,
    output logic [DEPTH-1:0][W-1:0]    mem_o,
    output logic [$clog2(DEPTH)-1:0]   head_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW-1:0]           head_q, tail_q;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[head_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= din_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (do_pop) head_q <= head_q + PW'(1);
            count_q <= count_d;
        end
    end

`ifdef REGBANK_WR_BYPASS_EN
    assign mem_o  = mem_q;
    assign head_o = head_q;
`endif

endmodule

// File: rtl/regbank_wr_demux8.sv
// Write side of the 8 x WIDTH register bank: buffered valid/ready writes,
// one-hot decoded commit, flat register export. Option: REGBANK_WR_BYPASS_EN.
module regbank_wr_demux8
    import regbank_wr_demux8_pkg::*;
#(
    parameter int WIDTH = REG_W,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [REG_AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        commit_en,
    output logic [NUM_REGS*WIDTH-1:0]   regs_flat,
    output logic [$clog2(DEPTH):0]      pend_cnt,
    output logic                        wr_done
);

    localparam int EW = REG_AW + WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [EW-1:0]                     head_ent;
    logic [CW-1:0]                     count;
    logic                              full, empty;
    logic                              push, commit;
    logic [NUM_REGS-1:0]               we;
    logic [NUM_REGS-1:0][WIDTH-1:0]    regs_q;
    logic [NUM_REGS-1:0][WIDTH-1:0]    regs_view;
    logic                              wr_done_q;

    // Ready depends only on stored occupancy, so a same-cycle pop never opens it
    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;
    assign commit   = commit_en && !empty;
    assign we       = dec_onehot(head_ent[EW-1 -: REG_AW], commit);

`ifdef REGBANK_WR_BYPASS_EN
    logic [DEPTH-1:0][EW-1:0] fifo_mem;
    logic [PW-1:0]            fifo_head;
`endif

    wr_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (commit),
        .din_i   ({wr_addr, wr_data}),
        .dout_o  (head_ent),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
`ifdef REGBANK_WR_BYPASS_EN
        ,
        .mem_o   (fifo_mem),
        .head_o  (fifo_head)
`endif
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)        regs_q[g] <= '0;
            else if (we[g]) regs_q[g] <= head_ent[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_done_q <= 1'b0;
        else     wr_done_q <= commit;
    end

`ifdef REGBANK_WR_BYPASS_EN
    // Walk oldest to youngest so the youngest pending write to an index wins
    logic [PW-1:0] slot;
    always_comb begin
        regs_view = regs_q;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = fifo_head + PW'(i);
            if (CW'(i) < count)
                regs_view[fifo_mem[slot][EW-1 -: REG_AW]] = fifo_mem[slot][WIDTH-1:0];
        end
    end
`else
    always_comb begin
        regs_view = regs_q;
    end
`endif

    assign regs_flat = regs_view;
    assign pend_cnt  = count;
    assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_regbank_wr_demux8.sv
// Self-checking bench for regbank_wr_demux8: directed scenarios plus random
// traffic against a queue-based reference model of the write buffer.
module tb_regbank_wr_demux8;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 wr_valid = 1'b0;
    logic                 wr_ready;
    logic [2:0]           wr_addr = '0;
    logic [WIDTH-1:0]     wr_data = '0;
    logic                 commit_en = 1'b0;
    logic [8*WIDTH-1:0]   regs_flat;
    logic [1:0]           pend_cnt;
    logic                 wr_done;

    int errors = 0;
    int checks = 0;

    regbank_wr_demux8 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .commit_en (commit_en),
        .regs_flat (regs_flat),
        .pend_cnt  (pend_cnt),
        .wr_done   (wr_done)
    );

    always #5 clk = ~clk;

    // reference model: committed regs, pending queue, done flag
    typedef struct {
        logic [2:0]       a;
        logic [WIDTH-1:0] d;
    } ent_t;

    logic [WIDTH-1:0] m_regs [8];
    ent_t             m_q [$];
    logic             m_done;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_q.delete();
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        bit   do_push, do_commit;
        ent_t e;
        do_push   = wr_valid && (m_q.size() != DEPTH);
        do_commit = commit_en && (m_q.size() != 0);
        if (do_commit) begin
            e = m_q.pop_front();
            m_regs[e.a] = e.d;
        end
        if (do_push) begin
            e.a = wr_addr;
            e.d = wr_data;
            m_q.push_back(e);
        end
        m_done = do_commit;
    endtask

    function automatic logic [8*WIDTH-1:0] exp_flat();
        logic [WIDTH-1:0] v [8];
        logic [8*WIDTH-1:0] f;
        for (int i = 0; i < 8; i++) v[i] = m_regs[i];
`ifdef REGBANK_WR_BYPASS_EN
        foreach (m_q[k]) v[m_q[k].a] = m_q[k].d;
`endif
        f = '0;
        for (int i = 0; i < 8; i++) f[i*WIDTH +: WIDTH] = v[i];
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] exp_reg(input int idx);
        logic [8*WIDTH-1:0] f;
        f = exp_flat();
        return f[idx*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0;
        commit_en = 1'b0;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs_flat); end
        checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL reset_pend: got %0d expected 0", pend_cnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
        checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", wr_done); end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        commit_en = 1'b1; wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        tick();
        wr_valid = 1'b0;
        checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL single_pend_after_push: got %0d expected 1", pend_cnt); end
        checks++; if (regs_flat[3*WIDTH +: WIDTH] !== exp_reg(3)) begin errors++; $display("FAIL single_reg3_early: got %h expected %h", regs_flat[3*WIDTH +: WIDTH], exp_reg(3)); end
        tick();
        checks++; if (regs_flat[3*WIDTH +: WIDTH] !== 16'hBEEF) begin errors++; $display("FAIL single_reg3: got %h expected beef", regs_flat[3*WIDTH +: WIDTH]); end
        checks++; if ((regs_flat & ~({{(4*WIDTH){1'b0}}, 16'hFFFF, {(3*WIDTH){1'b0}}})) !== '0) begin errors++; $display("FAIL single_others_zero: got %h", regs_flat); end
        checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL single_done_pulse: got %b expected 1", wr_done); end
        checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL single_pend_drained: got %0d expected 0", pend_cnt); end
        tick();
        checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL single_done_drop: got %b expected 0", wr_done); end
    endtask

    task automatic test_fill_drain();
        commit_en = 1'b0;
        wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA;
        tick();
        wr_addr = 3'd2; wr_data = 16'hBBBB;
        tick();
        checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL fill_pend: got %0d expected 2", pend_cnt); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_low: got %b expected 0", wr_ready); end
        wr_addr = 3'd4; wr_data = 16'hCCCC;
        tick();
        tick();
        checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL fill_third_held: got %0d expected 2", pend_cnt); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL fill_no_commit: got %h expected %h", regs_flat, exp_flat()); end
        wr_valid = 1'b0; commit_en = 1'b1;
        tick();
        checks++; if (regs_flat[1*WIDTH +: WIDTH] !== 16'hAAAA) begin errors++; $display("FAIL drain_first: got %h expected aaaa", regs_flat[1*WIDTH +: WIDTH]); end
        checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL drain_pend1: got %0d expected 1", pend_cnt); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL drain_first_view: got %h expected %h", regs_flat, exp_flat()); end
        tick();
        checks++; if (regs_flat[2*WIDTH +: WIDTH] !== 16'hBBBB) begin errors++; $display("FAIL drain_second: got %h expected bbbb", regs_flat[2*WIDTH +: WIDTH]); end
        checks++; if (regs_flat[4*WIDTH +: WIDTH] !== 16'h0000) begin errors++; $display("FAIL drain_rejected_absent: got %h expected 0000", regs_flat[4*WIDTH +: WIDTH]); end
        tick();
        checks++; if (wr_done !== 1'b0 || pend_cnt !== 2'd0) begin errors++; $display("FAIL drain_empty_commit: got done=%b pend=%0d expected done=0 pend=0", wr_done, pend_cnt); end
    endtask

    task automatic test_full_push_commit();
        commit_en = 1'b0; wr_valid = 1'b1;
        wr_addr = 3'd6; wr_data = 16'h0606; tick();
        wr_addr = 3'd0; wr_data = 16'h0A0A; tick();
        wr_addr = 3'd7; wr_data = 16'h0707; commit_en = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_commit_ready: got %b expected 0", wr_ready); end
        tick();
        wr_valid = 1'b0;
        checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL full_commit_pend: got %0d expected 1", pend_cnt); end
        tick();
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL full_commit_regs: got %h expected %h", regs_flat, exp_flat()); end
        checks++; if (regs_flat[7*WIDTH +: WIDTH] !== 16'h0000) begin errors++; $display("FAIL full_commit_reg7: got %h expected 0000", regs_flat[7*WIDTH +: WIDTH]); end
    endtask

    task automatic test_push_commit_same();
        commit_en = 1'b0; wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h0002;
        tick();
        wr_data = 16'h0001; commit_en = 1'b1;
        tick();
        wr_valid = 1'b0;
        checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL same_pend_held: got %0d expected 1", pend_cnt); end
        checks++; if (regs_flat[5*WIDTH +: WIDTH] !== exp_reg(5)) begin errors++; $display("FAIL same_reg5_first: got %h expected %h", regs_flat[5*WIDTH +: WIDTH], exp_reg(5)); end
        tick();
        checks++; if (regs_flat[5*WIDTH +: WIDTH] !== 16'h0001) begin errors++; $display("FAIL same_reg5_last: got %h expected 0001", regs_flat[5*WIDTH +: WIDTH]); end
        checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL same_pend_zero: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_reset_mid_drain();
        commit_en = 1'b0; wr_valid = 1'b1;
        wr_addr = 3'd2; wr_data = 16'h2222; tick();
        wr_addr = 3'd6; wr_data = 16'h6666; tick();
        wr_valid = 1'b0; commit_en = 1'b1;
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL rst_mid_regs: got %h expected 0", regs_flat); end
        checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL rst_mid_pend: got %0d expected 0", pend_cnt); end
        #1;
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (regs_flat !== '0 || wr_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_commit: got regs=%h done=%b expected 0/0", regs_flat, wr_done); end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] want;
        commit_en = 1'b0; wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234;
        tick();
        wr_valid = 1'b0;
`ifdef REGBANK_WR_BYPASS_EN
        want = 16'h1234;
`else
        want = 16'h0000;
`endif
        checks++; if (regs_flat[7*WIDTH +: WIDTH] !== want) begin errors++; $display("FAIL bypass_view: got %h expected %h", regs_flat[7*WIDTH +: WIDTH], want); end
        tick();
        checks++; if (regs_flat[7*WIDTH +: WIDTH] !== want) begin errors++; $display("FAIL bypass_hold: got %h expected %h", regs_flat[7*WIDTH +: WIDTH], want); end
        commit_en = 1'b1;
        tick();
        checks++; if (regs_flat[7*WIDTH +: WIDTH] !== 16'h1234) begin errors++; $display("FAIL bypass_commit: got %h expected 1234", regs_flat[7*WIDTH +: WIDTH]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_valid  = ($urandom_range(0, 3) != 0);
            commit_en = ($urandom_range(0, 2) != 0);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            #1;
            checks++; if (wr_ready !== (m_q.size() != DEPTH)) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, wr_ready, m_q.size() != DEPTH); end
            tick();
            checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL rand_regs[%0d]: got %h expected %h", n, regs_flat, exp_flat()); end
            checks++; if (pend_cnt !== 2'(m_q.size())) begin errors++; $display("FAIL rand_pend[%0d]: got %0d expected %0d", n, pend_cnt, m_q.size()); end
            checks++; if (wr_done !== m_done) begin errors++; $display("FAIL rand_done[%0d]: got %b expected %b", n, wr_done, m_done); end
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_fill_drain();
        test_full_push_commit();
        test_push_commit_same();
        test_reset_mid_drain();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
